// File: rtl/axil_reg_slave.sv
// ---------------------------------------------------------------------------
// axil_reg_slave
//   AXI4-Lite slave exposing NUM_REGS read/write registers of DATA_WIDTH
//   bits each. Write address and write data are accepted independently and
//   committed together. Reads run on their own FSM alongside writes.
//   Every register is also visible on the flattened REG_Q output.
//
// Ports
//   ACLK, ARESETn          : clock (rising edge) and synchronous active-low
//                            reset
//   AWADDR/AWVALID/AWREADY : write-address channel
//   WDATA/WSTRB/WVALID/WREADY : write-data channel with byte strobes
//   BRESP/BVALID/BREADY    : write-response channel (OKAY / SLVERR)
//   ARADDR/ARVALID/ARREADY : read-address channel
//   RDATA/RRESP/RVALID/RREADY : read-data channel (OKAY / SLVERR)
//   REG_Q                  : register i on bits [i*DATA_WIDTH +: DATA_WIDTH]
// ---------------------------------------------------------------------------
module axil_reg_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_Q
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;

  // One extra bit so NUM_REGS == 2**IDX_W is still representable.
  localparam logic [IDX_W:0] NREGS_C = (IDX_W+1)'(NUM_REGS);

  localparam logic [0:0] W_COLLECT = 1'b0;
  localparam logic [0:0] W_RESP    = 1'b1;
  localparam logic [0:0] R_IDLE    = 1'b0;
  localparam logic [0:0] R_DATA    = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // True when a register index addresses an implemented register.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < NREGS_C);
  endfunction

  // Byte-lane merge: strobed lanes take the new data, others keep old.
  function automatic logic [DATA_WIDTH-1:0] strobe_merge(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_val[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_val[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Write-side state
  logic [0:0]            w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic [IDX_W-1:0]      awidx_q,   awidx_d;
  logic                  w_held_q,  w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Read-side state
  logic [0:0]            r_state_q, r_state_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;

  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  ar_hs_s;
  logic                  commit_s;
  logic [IDX_W-1:0]      cm_idx_s;
  logic [DATA_WIDTH-1:0] cm_data_s;
  logic [STRB_W-1:0]     cm_strb_s;
  logic [IDX_W-1:0]      ar_idx_s;
  logic [DATA_WIDTH-1:0] rd_sel_s;

  // Byte-offset bits are decoded away; they only feed this reduction.
  logic                  unused_offset_s;
  assign unused_offset_s = ^{AWADDR[OFF_W-1:0], ARADDR[OFF_W-1:0]};

  // Readies are gated by ARESETn so they read 0 during reset and 1 as soon
  // as reset is released (state registers already hold the idle values).
  assign AWREADY = ARESETn && (w_state_q == W_COLLECT) && !aw_held_q;
  assign WREADY  = ARESETn && (w_state_q == W_COLLECT) && !w_held_q;
  assign ARREADY = ARESETn && (r_state_q == R_IDLE);

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;

  assign aw_hs_s = AWVALID && AWREADY;
  assign w_hs_s  = WVALID && WREADY;
  assign ar_hs_s = ARVALID && ARREADY;

  // A held payload wins over the live bus; the live bus is used only when
  // that channel is handshaking on this very edge.
  assign cm_idx_s  = aw_held_q ? awidx_q : AWADDR[ADDR_WIDTH-1:OFF_W];
  assign cm_data_s = w_held_q  ? wdata_q : WDATA;
  assign cm_strb_s = w_held_q  ? wstrb_q : WSTRB;
  assign commit_s  = (w_state_q == W_COLLECT) &&
                     (aw_held_q || aw_hs_s) && (w_held_q || w_hs_s);

  assign ar_idx_s = ARADDR[ADDR_WIDTH-1:OFF_W];

  // Flatten the register file onto REG_Q.
  always_comb begin
    REG_Q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      REG_Q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  // Read mux over the current (pre-commit) register values.
  always_comb begin
    rd_sel_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx_s == IDX_W'(i)) begin
        rd_sel_s = regs_q[i];
      end else begin
        rd_sel_s = rd_sel_s;
      end
    end
  end

  // Write FSM next state: collect AW and W independently, commit, respond.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    awidx_d   = awidx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    case (w_state_q)
      W_COLLECT: begin
        if (commit_s) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
          if (idx_in_range(cm_idx_s)) begin
            bresp_d = RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (cm_idx_s == IDX_W'(i)) begin
                regs_d[i] = strobe_merge(regs_q[i], cm_data_s, cm_strb_s);
              end else begin
                regs_d[i] = regs_q[i];
              end
            end
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end else begin
          if (aw_hs_s) begin
            aw_held_d = 1'b1;
            awidx_d   = AWADDR[ADDR_WIDTH-1:OFF_W];
          end else begin
            aw_held_d = aw_held_q;
            awidx_d   = awidx_q;
          end
          if (w_hs_s) begin
            w_held_d = 1'b1;
            wdata_d  = WDATA;
            wstrb_d  = WSTRB;
          end else begin
            w_held_d = w_held_q;
            wdata_d  = wdata_q;
            wstrb_d  = wstrb_q;
          end
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_COLLECT;
        end else begin
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_COLLECT;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Read FSM next state: capture data on AR handshake, hold until RREADY.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          if (idx_in_range(ar_idx_s)) begin
            rdata_d = rd_sel_s;
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end else begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end else begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  // Write-side registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state_q <= W_COLLECT;
      aw_held_q <= 1'b0;
      awidx_q   <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      awidx_q   <= awidx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read-side registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axil_reg_slave
//   Self-checking bench for axil_reg_slave (default parameters: 8-bit
//   address, 32-bit data, 16 registers). A register-array model tracks the
//   expected contents; directed scenarios plus randomized reads and writes
//   are checked against it.
// ---------------------------------------------------------------------------
module tb_axil_reg_slave;

  logic         ACLK;
  logic         ARESETn;
  logic [7:0]   AWADDR;
  logic         AWVALID;
  logic         AWREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         WVALID;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic [7:0]   ARADDR;
  logic         ARVALID;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY;
  logic [511:0] REG_Q;

  int total = 0;
  int bad   = 0;

  logic [31:0] mreg [16];

  axil_reg_slave #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .NUM_REGS(16)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .REG_Q(REG_Q)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: byte address / 4 selects a register; 16 registers exist.
  task automatic model_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
    int idx;
    idx = int'(a) / 4;
    if (idx >= 16) begin
      resp = 2'b10;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (s[k]) mreg[idx][8*k +: 8] = d[8*k +: 8];
      end
      resp = 2'b00;
    end
  endtask

  task automatic model_read(input logic [7:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
    int idx;
    idx = int'(a) / 4;
    if (idx >= 16) begin
      d = 32'h0; resp = 2'b10;
    end else begin
      d = mreg[idx]; resp = 2'b00;
    end
  endtask

  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = mreg[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mreg[i] = 32'h0;
  endtask

  // Called at a negedge with the DUT idle. AW is offered from cycle aw_at,
  // W from cycle w_at; a channel already taken keeps probing with junk to
  // confirm it is stalled. BREADY is held low for b_wait cycles.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_at,
                          input int w_at, input int b_wait);
    bit aw_done, w_done, hs_aw, hs_w;
    int cyc;
    int lat;
    logic [1:0] exp_resp;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    lat = ((aw_at > w_at) ? aw_at : w_at) + 1;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (aw_done) begin
        AWVALID = 1'b1; AWADDR = ~addr;
      end else begin
        AWVALID = (cyc >= aw_at); AWADDR = addr;
      end
      if (w_done) begin
        WVALID = 1'b1; WDATA = ~data; WSTRB = ~strb;
      end else begin
        WVALID = (cyc >= w_at); WDATA = data; WSTRB = strb;
      end
      #1;
      if (aw_done) chk("awready_stall", AWREADY, 1'b0);
      if (w_done)  chk("wready_stall", WREADY, 1'b0);
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      @(posedge ACLK);
      aw_done = aw_done | hs_aw;
      w_done  = w_done | hs_w;
      @(negedge ACLK);
      cyc++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("wr_latency", cyc, lat);
    model_write(addr, data, strb, exp_resp);
    chk("bvalid_set", BVALID, 1'b1);
    chk("bresp", BRESP, exp_resp);
    chk("regq_after_write", REG_Q, model_flat());
    for (int i = 0; i < b_wait; i++) begin
      BREADY = 1'b0;
      @(posedge ACLK); @(negedge ACLK);
      chk("bvalid_hold", BVALID, 1'b1);
      chk("bresp_hold", BRESP, exp_resp);
      chk("readies_low_in_resp", {AWREADY, WREADY}, 2'b00);
    end
    BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0;
    chk("bvalid_clear", BVALID, 1'b0);
    chk("readies_back", {AWREADY, WREADY}, 2'b11);
  endtask

  // Called at a negedge with the read side idle.
  task automatic do_read(input logic [7:0] addr, input int ar_at, input int r_wait);
    bit hs;
    int cyc;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    for (int i = 0; i < ar_at; i++) begin
      @(posedge ACLK); @(negedge ACLK);
    end
    ARVALID = 1'b1; ARADDR = addr; hs = 1'b0; cyc = 0;
    while (!hs && cyc < 20) begin
      #1;
      hs = ARREADY;
      @(posedge ACLK); @(negedge ACLK);
      cyc++;
    end
    ARVALID = 1'b0;
    chk("rd_latency", cyc, 1);
    model_read(addr, exp_d, exp_r);
    chk("rvalid_set", RVALID, 1'b1);
    chk("rdata", RDATA, exp_d);
    chk("rresp", RRESP, exp_r);
    for (int i = 0; i < r_wait; i++) begin
      @(posedge ACLK); @(negedge ACLK);
      chk("rhold", {RVALID, ARREADY, RRESP, RDATA}, {1'b1, 1'b0, exp_r, exp_d});
    end
    RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    RREADY = 1'b0;
    chk("rvalid_clear", {RVALID, ARREADY}, 2'b01);
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] d, exp_d;
    logic [3:0]  s;
    logic [1:0]  exp_r, exp_b;
    logic [31:0] slice;

    ARESETn = 1'b0; AWADDR = 8'h0; AWVALID = 1'b0; WDATA = 32'h0;
    WSTRB = 4'h0; WVALID = 1'b0; BREADY = 1'b0; ARADDR = 8'h0;
    ARVALID = 1'b0; RREADY = 1'b0;
    model_clear();

    // Reset state
    @(posedge ACLK); @(posedge ACLK); @(negedge ACLK);
    chk("rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("rst_valids", {BVALID, RVALID}, 2'b00);
    chk("rst_resps", {BRESP, RRESP}, 4'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_regq", REG_Q, 512'h0);
    ARESETn = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    chk("post_rst_readies", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Same-cycle AW/W, then read back
    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(8'h08, 0, 0);

    // W first with partial strobe, AW three cycles later
    do_write(8'h08, 32'h11223344, 4'h5, 3, 0, 0);
    slice = REG_Q[95:64];
    chk("partial_strobe", slice, 32'hDE22BE44);
    do_read(8'h09, 1, 2);

    // Out-of-range address
    do_write(8'h40, 32'h12345678, 4'hF, 0, 0, 0);
    do_read(8'h40, 0, 0);

    // BREADY held low five cycles
    do_write(8'h0C, 32'hCAFE0001, 4'hF, 1, 0, 5);
    do_read(8'h0C, 0, 3);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      else a = 8'($urandom_range(64, 255));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) < 3)
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset one cycle after an AW handshake, W never sent
    AWVALID = 1'b1; AWADDR = 8'h0C;
    #1;
    chk("mid_aw_ready", AWREADY, 1'b1);
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0; ARESETn = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    ARESETn = 1'b1;
    model_clear();
    chk("mid_rst_bvalid", BVALID, 1'b0);
    chk("mid_rst_regq", REG_Q, model_flat());
    @(posedge ACLK); @(negedge ACLK);
    chk("mid_rst_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
    WVALID = 1'b1; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF;
    @(posedge ACLK); @(negedge ACLK);
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("no_commit_after_rst", {BVALID, REG_Q}, {1'b0, 512'h0});
      @(posedge ACLK); @(negedge ACLK);
    end
    ARESETn = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK); @(negedge ACLK);

    // Read and write commit of 0x04 on the same edge
    AWVALID = 1'b1; AWADDR = 8'h04; WVALID = 1'b1; WDATA = 32'h5; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 8'h04;
    #1;
    chk("same_edge_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    model_read(8'h04, exp_d, exp_r);
    model_write(8'h04, 32'h5, 4'hF, exp_b);
    chk("same_edge_rvalid", RVALID, 1'b1);
    chk("same_edge_rdata_old", RDATA, exp_d);
    chk("same_edge_rresp", RRESP, exp_r);
    chk("same_edge_b", {BVALID, BRESP}, {1'b1, exp_b});
    slice = REG_Q[63:32];
    chk("same_edge_reg1", slice, 32'h5);
    chk("same_edge_regq", REG_Q, model_flat());
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    chk("same_edge_done", {BVALID, RVALID}, 2'b00);
    do_read(8'h04, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
